// File: rtl/pulse_to_level_pkg.sv
// Shared definitions for the pulse/level converter family: state encoding and sizing helpers.
package pulse_to_level_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_e;

  // Gap counter width; at least one bit even when the gap is disabled.
  function automatic int unsigned gap_cnt_w(input int unsigned gap_cycles);
    if (gap_cycles == 0) begin
      return 1;
    end
    return $clog2(gap_cycles + 1);
  endfunction

endpackage

// File: rtl/pulse_to_level_down_counter_ld.sv
// Loadable down counter that saturates at zero; zero flag reflects the current count.
module down_counter_ld #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load wins over decrement; decrement only from a nonzero count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_to_level.sv
// Stretches single-cycle pulses into a level of programmable length, with optional
// retrigger and an enforced low gap before the next pulse is accepted.
module pulse_to_level
  import pulse_to_level_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned RETRIGGER  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pulse,
  input  logic [WIDTH-1:0]   hold_len,
  output logic               level,
  output logic               busy,
  output logic               missed,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned      GAP_W    = gap_cnt_w(GAP_CYCLES);
  localparam int unsigned      GAP_INIT = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_INIT);

  state_e           state_q;
  state_e           state_d;
  logic             level_d;
  logic             missed_d;
  logic             hold_load;
  logic             hold_en;
  logic             hold_zero;
  logic [WIDTH-1:0] len_m1;
  logic             gap_load;
  logic             gap_en;
  logic             gap_zero;

  // A zero length request is treated as a one-cycle level.
  assign len_m1 = (hold_len == '0) ? '0 : (hold_len - WIDTH'(1));

  down_counter_ld #(
    .W (WIDTH)
  ) u_hold_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_val (len_m1),
    .en       (hold_en),
    .zero     (hold_zero)
  );

  down_counter_ld #(
    .W (GAP_W)
  ) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (gap_en),
    .zero     (gap_zero)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      level   <= 1'b0;
      missed  <= 1'b0;
    end else begin
      state_q <= state_d;
      level   <= level_d;
      missed  <= missed_d;
    end
  end

  assign state = state_q;
  assign busy  = (state_q != IDLE);

  // Next-state, next-output and counter control.
  always_comb begin
    state_d   = state_q;
    level_d   = 1'b0;
    missed_d  = 1'b0;
    hold_load = 1'b0;
    hold_en   = 1'b0;
    gap_load  = 1'b0;
    gap_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pulse) begin
          hold_load = 1'b1;
          level_d   = 1'b1;
          state_d   = HOLD;
        end
      end

      HOLD: begin
        if (pulse && (RETRIGGER != 0)) begin
          hold_load = 1'b1;
          level_d   = 1'b1;
        end else begin
          missed_d = pulse;
          if (!hold_zero) begin
            hold_en = 1'b1;
            level_d = 1'b1;
          end else if (GAP_CYCLES != 0) begin
            gap_load = 1'b1;
            state_d  = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end

      GAP: begin
        missed_d = pulse;
        if (gap_zero) begin
          state_d = IDLE;
        end else begin
          gap_en = 1'b1;
        end
      end

      // The unused encoding falls back to IDLE with the level low.
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed scoreboard bench: two instances (retrigger on/off) share stimulus; each
// step queues hand-computed {level,busy,missed,state} expectations for a monitor.
module tb_pulse_to_level;

  localparam logic [1:0] SI = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SG = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse = 1'b0;
  logic [7:0] hold_len = 8'd0;

  logic       lv_a, bz_a, ms_a;
  logic [1:0] st_a;
  logic       lv_b, bz_b, ms_b;
  logic [1:0] st_b;

  always #5 clk = ~clk;

  pulse_to_level #(.WIDTH(8), .GAP_CYCLES(2), .RETRIGGER(1)) dut_a (
    .clk(clk), .reset(reset), .pulse(pulse), .hold_len(hold_len),
    .level(lv_a), .busy(bz_a), .missed(ms_a), .state(st_a)
  );

  pulse_to_level #(.WIDTH(8), .GAP_CYCLES(2), .RETRIGGER(0)) dut_b (
    .clk(clk), .reset(reset), .pulse(pulse), .hold_len(hold_len),
    .level(lv_b), .busy(bz_b), .missed(ms_b), .state(st_b)
  );

  typedef struct {
    string      tag;
    logic [4:0] ea;
    logic [4:0] eb;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  string tag = "reset";

  function automatic logic [4:0] e(input logic l, input logic m, input logic [1:0] s);
    return {l, (s != 2'b00), m, s};
  endfunction

  task automatic step(input logic r, input logic p, input logic [7:0] hl,
                      input logic [4:0] xa, input logic [4:0] xb);
    exp_t x;
    @(negedge clk);
    reset    = r;
    pulse    = p;
    hold_len = hl;
    x.tag = tag;
    x.ea  = xa;
    x.eb  = xb;
    sb.push_back(x);
    @(posedge clk);
  endtask

  task automatic step_s(input logic r, input logic p, input logic [7:0] hl, input logic [4:0] x);
    step(r, p, hl, x, x);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      checks++;
      if ({lv_a, bz_a, ms_a, st_a} !== x.ea) begin
        failures++;
        $display("FAIL %s retrig=1 got {lvl,busy,miss,st}=%b want=%b", x.tag, {lv_a, bz_a, ms_a, st_a}, x.ea);
      end
      checks++;
      if ({lv_b, bz_b, ms_b, st_b} !== x.eb) begin
        failures++;
        $display("FAIL %s retrig=0 got {lvl,busy,miss,st}=%b want=%b", x.tag, {lv_b, bz_b, ms_b, st_b}, x.eb);
      end
    end
  end

  initial begin
    tag = "reset";
    step_s(1, 0, 0, e(0, 0, SI));
    step_s(0, 0, 0, e(0, 0, SI));

    tag = "len4";
    step_s(0, 1, 4, e(1, 0, SH));
    step_s(0, 0, 4, e(1, 0, SH));
    step_s(0, 0, 4, e(1, 0, SH));
    step_s(0, 0, 4, e(1, 0, SH));
    step_s(0, 0, 4, e(0, 0, SG));
    step_s(0, 0, 4, e(0, 0, SG));
    step_s(0, 0, 4, e(0, 0, SI));
    step_s(0, 0, 4, e(0, 0, SI));

    tag = "len0";
    step_s(0, 1, 0, e(1, 0, SH));
    step_s(0, 0, 0, e(0, 0, SG));
    step_s(0, 1, 0, e(0, 1, SG));
    step_s(0, 0, 0, e(0, 0, SI));
    step_s(0, 1, 0, e(1, 0, SH));
    step_s(0, 0, 0, e(0, 0, SG));
    step_s(0, 0, 0, e(0, 0, SG));
    step_s(0, 0, 0, e(0, 0, SI));

    tag = "retrig_mid";
    step_s(0, 1, 5, e(1, 0, SH));
    step_s(0, 0, 5, e(1, 0, SH));
    step  (0, 1, 3, e(1, 0, SH), e(1, 1, SH));
    step_s(0, 0, 0, e(1, 0, SH));
    step_s(0, 0, 0, e(1, 0, SH));
    step_s(0, 0, 0, e(0, 0, SG));
    step_s(0, 0, 0, e(0, 0, SG));
    step_s(0, 0, 0, e(0, 0, SI));

    tag = "retrig_last";
    step_s(0, 1, 2, e(1, 0, SH));
    step_s(0, 0, 2, e(1, 0, SH));
    step  (0, 1, 3, e(1, 0, SH), e(0, 1, SG));
    step  (0, 0, 0, e(1, 0, SH), e(0, 0, SG));
    step  (0, 0, 0, e(1, 0, SH), e(0, 0, SI));
    step  (0, 0, 0, e(0, 0, SG), e(0, 0, SI));
    step  (0, 0, 0, e(0, 0, SG), e(0, 0, SI));
    step_s(0, 0, 0, e(0, 0, SI));

    tag = "gap_last";
    step_s(0, 1, 1, e(1, 0, SH));
    step_s(0, 0, 1, e(0, 0, SG));
    step_s(0, 0, 1, e(0, 0, SG));
    step_s(0, 1, 1, e(0, 1, SI));
    step_s(0, 1, 1, e(1, 0, SH));
    step_s(0, 0, 1, e(0, 0, SG));
    step_s(0, 0, 1, e(0, 0, SG));
    step_s(0, 0, 1, e(0, 0, SI));

    tag = "reset_hold";
    step_s(0, 1, 10, e(1, 0, SH));
    step_s(0, 0, 10, e(1, 0, SH));
    step_s(1, 1, 10, e(0, 0, SI));
    step_s(0, 1, 10, e(1, 0, SH));
    for (int i = 0; i < 9; i++) begin
      step_s(0, 0, 10, e(1, 0, SH));
    end
    step_s(0, 0, 10, e(0, 0, SG));
    step_s(0, 0, 10, e(0, 0, SG));
    step_s(0, 0, 10, e(0, 0, SI));
    step_s(0, 0, 10, e(0, 0, SI));

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
